// File: rtl/divisor_scheduler.sv
// Issue stage for an iterative divider: queues operand pairs, launches one division at a
// time, short-circuits zero denominators and aborts hung divisions with a watchdog.
module divisor_scheduler #(
  parameter int size    = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            In_Valid,
  output logic            In_Ready,
  input  logic [size-1:0] In_Num,
  input  logic [size-1:0] In_Den,
  output logic            Start,
  output logic [size-1:0] Num,
  output logic [size-1:0] Den,
  input  logic [size-1:0] Coc,
  input  logic [size-1:0] Res,
  input  logic            Done,
  output logic            Out_Valid,
  input  logic            Out_Ready,
  output logic [size-1:0] Out_Coc,
  output logic [size-1:0] Out_Res,
  output logic [1:0]      Out_Status
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t          state, state_nxt;
  logic [size-1:0] fifo_num [DEPTH];
  logic [size-1:0] fifo_den [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [WDW-1:0]  wd;
  logic            push, pop, head_zero, wd_expired;

  // Ready comes from the registered count so a same-cycle pop cannot reopen a full queue.
  assign In_Ready   = (count != FULL_CNT);
  assign push       = In_Valid && In_Ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign head_zero  = (fifo_den[rd_ptr] == '0);
  assign wd_expired = (wd == WD_LAST);
  assign Start      = (state == ISSUE);
  assign Out_Valid  = (state == HOLD);

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_num[wr_ptr] <= In_Num;
      fifo_den[wr_ptr] <= In_Den;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = head_zero ? HOLD : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (Done || wd_expired) state_nxt = HOLD;
      HOLD:    if (Out_Ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/result registers; Done is checked before the watchdog so it wins a tie.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Num        <= '0;
      Den        <= '0;
      Out_Coc    <= '0;
      Out_Res    <= '0;
      Out_Status <= 2'b00;
      wd         <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          Num <= fifo_num[rd_ptr];
          Den <= fifo_den[rd_ptr];
          if (head_zero) begin
            Out_Coc    <= '1;
            Out_Res    <= fifo_num[rd_ptr];
            Out_Status <= 2'b01;
          end
        end
        ISSUE: wd <= '0;
        WAIT: begin
          if (Done) begin
            Out_Coc    <= Coc;
            Out_Res    <= Res;
            Out_Status <= 2'b00;
          end else if (wd_expired) begin
            Out_Coc    <= '0;
            Out_Res    <= '0;
            Out_Status <= 2'b10;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_scheduler.sv
// Directed bench for divisor_scheduler with a behavioural divider (Done size+2 cycles after
// Start) on the main instance and a second instance whose divider never answers.
module tb_divisor_scheduler;
  localparam int W = 32;

  logic         CLK = 0;
  logic         RST = 1;
  logic         In_Valid = 0, In_Ready;
  logic [W-1:0] In_Num = '0, In_Den = '0;
  logic         Start, Done;
  logic [W-1:0] Num, Den, Coc, Res;
  logic         Out_Valid, Out_Ready = 1;
  logic [W-1:0] Out_Coc, Out_Res;
  logic [1:0]   Out_Status;

  logic         b_in_valid = 0, b_in_ready, b_start, b_out_valid, b_out_ready = 1;
  logic [W-1:0] b_in_num = '0, b_in_den = '0, b_num, b_den, b_out_coc, b_out_res;
  logic [1:0]   b_out_status;

  always #5 CLK = ~CLK;

  divisor_scheduler #(.size(W), .DEPTH(4), .TIMEOUT(255)) dut (
    .CLK(CLK), .RST(RST), .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Num(In_Num),
    .In_Den(In_Den), .Start(Start), .Num(Num), .Den(Den), .Coc(Coc), .Res(Res), .Done(Done),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Coc(Out_Coc), .Out_Res(Out_Res),
    .Out_Status(Out_Status));

  divisor_scheduler #(.size(W), .DEPTH(4), .TIMEOUT(20)) dut_hung (
    .CLK(CLK), .RST(RST), .In_Valid(b_in_valid), .In_Ready(b_in_ready), .In_Num(b_in_num),
    .In_Den(b_in_den), .Start(b_start), .Num(b_num), .Den(b_den), .Coc('0), .Res('0),
    .Done(1'b0), .Out_Valid(b_out_valid), .Out_Ready(b_out_ready), .Out_Coc(b_out_coc),
    .Out_Res(b_out_res), .Out_Status(b_out_status));

  // Behavioural divider, deliberately not reset so a late Done can follow RST.
  int unsigned  dcnt = 0;
  logic [W-1:0] dq = '0, dr = '0;
  always @(posedge CLK) begin
    if (Start) begin
      dcnt <= W + 2;
      dq   <= Num / Den;
      dr   <= Num % Den;
    end else if (dcnt != 0) dcnt <= dcnt - 1;
  end
  assign Done = (dcnt == 1);
  assign Coc  = dq;
  assign Res  = dr;

  int           start_cnt = 0, valid_cnt = 0, done_cnt = 0;
  logic [W-1:0] start_num = '0, start_den = '0;
  logic         done_q = 0;
  always @(posedge CLK) begin
    if (Start) begin
      start_cnt <= start_cnt + 1;
      start_num <= Num;
      start_den <= Den;
    end
    if (Out_Valid) valid_cnt <= valid_cnt + 1;
    if (Done) done_cnt <= done_cnt + 1;
    done_q <= Done;
  end

  int tests = 0, failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [W-1:0] n, input logic [W-1:0] d);
    In_Valid = 1; In_Num = n; In_Den = d;
    tick();
    In_Valid = 0;
  endtask

  task automatic push_b(input logic [W-1:0] n, input logic [W-1:0] d);
    b_in_valid = 1; b_in_num = n; b_in_den = d;
    tick();
    b_in_valid = 0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!Out_Valid && n < budget) begin
      tick();
      n++;
    end
    check({name, "_valid"}, Out_Valid, 1);
  endtask

  typedef struct {
    logic [W-1:0] num, den, coc, res;
    logic [1:0]   st;
  } vec_t;
  vec_t vt[6];
  vec_t q3[5];

  initial begin
    int s0, s1, v1, d1, n;
    bit ok;
    vt[0] = '{num: 100,          den: 7,  coc: 14,           res: 2,  st: 2'b00};
    vt[1] = '{num: 5,            den: 0,  coc: 32'hFFFFFFFF, res: 5,  st: 2'b01};
    vt[2] = '{num: 0,            den: 3,  coc: 0,            res: 0,  st: 2'b00};
    vt[3] = '{num: 32'hFFFFFFFF, den: 1,  coc: 32'hFFFFFFFF, res: 0,  st: 2'b00};
    vt[4] = '{num: 7,            den: 100,coc: 0,            res: 7,  st: 2'b00};
    vt[5] = '{num: 0,            den: 0,  coc: 32'hFFFFFFFF, res: 0,  st: 2'b01};
    q3[0] = '{num: 20,   den: 3,  coc: 6,            res: 2,  st: 2'b00};
    q3[1] = '{num: 9,    den: 0,  coc: 32'hFFFFFFFF, res: 9,  st: 2'b01};
    q3[2] = '{num: 1000, den: 10, coc: 100,          res: 0,  st: 2'b00};
    q3[3] = '{num: 17,   den: 5,  coc: 3,            res: 2,  st: 2'b00};
    q3[4] = '{num: 255,  den: 16, coc: 15,           res: 15, st: 2'b00};

    RST = 1;
    tick(); tick();
    check("rst_in_ready", In_Ready, 1);
    check("rst_out_valid", Out_Valid, 0);
    check("rst_start", Start, 0);
    check("rst_num_den", {Num, Den}, 0);
    check("rst_out_data", {Out_Coc, Out_Res}, 0);
    check("rst_status", Out_Status, 0);
    RST = 0;
    tick();

    // Start latency and one-cycle pulse
    push(100, 7);
    check("lat_start_k1", Start, 0);
    tick();
    check("lat_start_k2", Start, 1);
    check("lat_num_den", {Num, Den}, {32'd100, 32'd7});
    tick();
    check("lat_start_pulse", Start, 0);
    wait_valid("lat", 60);
    check("lat_done_to_valid", done_q, 1);
    check("lat_coc_res", {Out_Coc, Out_Res}, {32'd14, 32'd2});
    tick();

    // Zero denominator: result in k+2, no Start
    s0 = start_cnt;
    push(5, 0);
    check("zd_valid_k1", Out_Valid, 0);
    tick();
    check("zd_valid_k2", Out_Valid, 1);
    check("zd_result", {Out_Coc, Out_Res, 30'd0, Out_Status}, {32'hFFFFFFFF, 32'd5, 32'd1});
    check("zd_no_start", start_cnt - s0, 0);
    tick();

    for (int i = 0; i < 6; i++) begin
      s0 = start_cnt;
      push(vt[i].num, vt[i].den);
      wait_valid($sformatf("vec%0d", i), 60);
      check($sformatf("vec%0d_coc", i), Out_Coc, vt[i].coc);
      check($sformatf("vec%0d_res", i), Out_Res, vt[i].res);
      check($sformatf("vec%0d_status", i), Out_Status, vt[i].st);
      check($sformatf("vec%0d_starts", i), start_cnt - s0, (vt[i].den != 0) ? 1 : 0);
      if (vt[i].den != 0) begin
        check($sformatf("vec%0d_start_ops", i), {start_num, start_den}, {vt[i].num, vt[i].den});
        check($sformatf("vec%0d_done_to_valid", i), done_q, 1);
      end
      tick();
    end

    // Fill the queue with the consumer stalled, then drain in order
    Out_Ready = 0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fill_ready%0d", i), In_Ready, 1);
      push(q3[i].num, q3[i].den);
    end
    check("fill_full", In_Ready, 0);
    In_Valid = 1; In_Num = 99; In_Den = 9;
    tick();
    In_Valid = 0;
    check("fill_still_full", In_Ready, 0);
    wait_valid("fill_first", 60);
    Out_Ready = 1;
    for (int i = 0; i < 5; i++) begin
      wait_valid($sformatf("drain%0d", i), 60);
      check($sformatf("drain%0d_data", i), {Out_Coc, Out_Res, 30'd0, Out_Status},
            {q3[i].coc, q3[i].res, 30'd0, q3[i].st});
      tick();
    end
    v1 = valid_cnt;
    for (int i = 0; i < 60; i++) tick();
    check("drain_no_extra", valid_cnt - v1, 0);
    check("drain_empty_ready", In_Ready, 1);

    // Held result stays frozen and blocks the next issue
    Out_Ready = 0;
    push(100, 7);
    push(50, 6);
    wait_valid("hold", 60);
    s0 = start_cnt;
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Out_Valid !== 1 || Out_Coc !== 14 || Out_Res !== 2 || Out_Status !== 0) ok = 0;
    end
    check("hold_stable", ok, 1);
    check("hold_no_start", start_cnt - s0, 0);
    Out_Ready = 1;
    tick();
    check("hold_release_start_early", Start, 0);
    tick();
    check("hold_release_start", Start, 1);
    wait_valid("hold_next", 60);
    check("hold_next_data", {Out_Coc, Out_Res}, {32'd8, 32'd2});
    tick();

    // Watchdog on the instance whose divider never completes
    push_b(30, 4);
    push_b(8, 0);
    check("wd_start", b_start, 1);
    tick();
    n = 0;
    while (!b_out_valid && n < 40) begin
      tick();
      n++;
    end
    check("wd_wait_cycles", n, 20);
    check("wd_result", {b_out_coc, b_out_res, 30'd0, b_out_status}, {32'd0, 32'd0, 32'd2});
    tick();
    n = 0;
    while (!b_out_valid && n < 10) begin
      tick();
      n++;
    end
    check("wd_resume_valid", b_out_valid, 1);
    check("wd_resume_result", {b_out_coc, b_out_res, 30'd0, b_out_status},
          {32'hFFFFFFFF, 32'd8, 32'd1});
    tick();

    // Reset while waiting with two jobs queued
    s0 = start_cnt;
    push(40, 3);
    push(41, 3);
    push(42, 3);
    check("rstmid_issued", start_cnt - s0, 1);
    for (int i = 0; i < 5; i++) tick();
    RST = 1;
    tick();
    RST = 0;
    check("rstmid_out_valid", Out_Valid, 0);
    check("rstmid_in_ready", In_Ready, 1);
    check("rstmid_start", Start, 0);
    s1 = start_cnt; v1 = valid_cnt; d1 = done_cnt;
    for (int i = 0; i < 50; i++) tick();
    check("rstmid_late_done_seen", (done_cnt - d1) > 0, 1);
    check("rstmid_no_start", start_cnt - s1, 0);
    check("rstmid_no_valid", valid_cnt - v1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, limit 500000");
    $fatal(1, "timeout");
  end
endmodule
